// File: rtl/bcd_timekeeper_if.sv
// rtl/bcd_timekeeper_if.sv - control and display bundle for the time-of-day counter
interface bcd_timekeeper_if;
  logic       run;
  logic       mode_12h;
  logic [5:0] digit;
  logic       up;
  logic       down;
  logic [3:0] sec0;
  logic [3:0] sec1;
  logic [3:0] min0;
  logic [3:0] min1;
  logic [3:0] hrs0;
  logic [3:0] hrs1;
  logic       pm;
  logic       sec_tick;
  logic       day_tick;

  modport master (
    output run, mode_12h, digit, up, down,
    input  sec0, sec1, min0, min1, hrs0, hrs1, pm, sec_tick, day_tick
  );

  modport slave (
    input  run, mode_12h, digit, up, down,
    output sec0, sec1, min0, min1, hrs0, hrs1, pm, sec_tick, day_tick
  );
endinterface

// File: rtl/bcd_timekeeper.sv
// rtl/bcd_timekeeper.sv - prescaled hh:mm:ss counter with field setting and 12/24-hour display
module bcd_timekeeper #(
  parameter  int DIV = 6000000,
  localparam int PW  = $clog2(DIV)
) (
  input  logic clk_6mhz,
  input  logic rst,
  bcd_timekeeper_if.slave bus
);

  logic [PW-1:0] pre;
  logic [3:0]    sec0_r, sec1_r, min0_r, min1_r;
  logic [4:0]    hr;
  logic          up_q, down_q;
  logic          sec_tick_r, day_tick_r;

  logic set_mode, up_e, down_e, adjust, tick, at_max;
  logic [4:0] hdisp;

  assign set_mode = (bus.digit != 6'd0);
  assign up_e     = bus.up & ~up_q;
  assign down_e   = bus.down & ~down_q;
  assign adjust   = $onehot(bus.digit) && (up_e ^ down_e);
  assign tick     = bus.run && !set_mode && (pre == PW'(DIV - 1));
  assign at_max   = (hr == 5'd23) && (min1_r == 4'd5) && (min0_r == 4'd9) &&
                    (sec1_r == 4'd5) && (sec0_r == 4'd9);

  function automatic logic [3:0] step(input logic [3:0] v, input logic [3:0] top,
                                      input logic inc);
    if (inc) return (v == top) ? 4'd0 : v + 4'd1;
    return (v == 4'd0) ? top : v - 4'd1;
  endfunction

  always_ff @(posedge clk_6mhz) begin
    if (rst) begin
      pre        <= '0;
      sec0_r     <= 4'd0;
      sec1_r     <= 4'd0;
      min0_r     <= 4'd0;
      min1_r     <= 4'd0;
      hr         <= 5'd0;
      up_q       <= 1'b0;
      down_q     <= 1'b0;
      sec_tick_r <= 1'b0;
      day_tick_r <= 1'b0;
    end else begin
      up_q       <= bus.up;
      down_q     <= bus.down;
      sec_tick_r <= 1'b0;
      day_tick_r <= 1'b0;

      // Holding pre at 0 in set mode gives a full period after release.
      if (set_mode)
        pre <= '0;
      else if (bus.run)
        pre <= (pre == PW'(DIV - 1)) ? '0 : pre + PW'(1);

      if (tick) begin
        sec_tick_r <= 1'b1;
        day_tick_r <= at_max;
        if (sec0_r != 4'd9) sec0_r <= sec0_r + 4'd1;
        else begin
          sec0_r <= 4'd0;
          if (sec1_r != 4'd5) sec1_r <= sec1_r + 4'd1;
          else begin
            sec1_r <= 4'd0;
            if (min0_r != 4'd9) min0_r <= min0_r + 4'd1;
            else begin
              min0_r <= 4'd0;
              if (min1_r != 4'd5) min1_r <= min1_r + 4'd1;
              else begin
                min1_r <= 4'd0;
                hr     <= (hr == 5'd23) ? 5'd0 : hr + 5'd1;
              end
            end
          end
        end
      end else if (adjust) begin
        case (bus.digit)
          6'b100000: sec0_r <= step(sec0_r, 4'd9, up_e);
          6'b010000: sec1_r <= step(sec1_r, 4'd5, up_e);
          6'b001000: min0_r <= step(min0_r, 4'd9, up_e);
          6'b000100: min1_r <= step(min1_r, 4'd5, up_e);
          6'b000010: hr <= up_e ? ((hr == 5'd23) ? 5'd0 : hr + 5'd1)
                                : ((hr == 5'd0) ? 5'd23 : hr - 5'd1);
          6'b000001: hr <= up_e ? ((hr >= 5'd14) ? hr - 5'd14 : hr + 5'd10)
                                : ((hr >= 5'd10) ? hr - 5'd10 : hr + 5'd14);
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    hdisp = hr;
    if (bus.mode_12h) begin
      if (hr == 5'd0)       hdisp = 5'd12;
      else if (hr > 5'd12)  hdisp = hr - 5'd12;
    end
    if (hdisp >= 5'd20) begin
      bus.hrs1 = 4'd2;
      bus.hrs0 = 4'(hdisp - 5'd20);
    end else if (hdisp >= 5'd10) begin
      bus.hrs1 = 4'd1;
      bus.hrs0 = 4'(hdisp - 5'd10);
    end else begin
      bus.hrs1 = 4'd0;
      bus.hrs0 = 4'(hdisp);
    end
  end

  assign bus.pm       = (hr >= 5'd12);
  assign bus.sec0     = sec0_r;
  assign bus.sec1     = sec1_r;
  assign bus.min0     = min0_r;
  assign bus.min1     = min1_r;
  assign bus.sec_tick = sec_tick_r;
  assign bus.day_tick = day_tick_r;

endmodule

// File: doc/bcd_timekeeper.md
# bcd_timekeeper

- Parametrised successor to the fixed 6 MHz hh:mm:ss watch counter.
- Generates its own 1 Hz tick from a parametrised prescaler, keeps time of day, and adds a runtime 12/24-hour display mode with a PM flag.
- Field setting is edge-detected, per-field range-legal and wrap-around.
- Emits second and day-rollover strobes for the alarm, stopwatch and date blocks downstream.

## Interface
Parameters:
- DIV, 6000000: clk_6mhz cycles per second tick; must be ≥2.
- PW, $clog2(DIV): prescaler width (derived, not overridden).

Ports:
- clk_6mhz  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- run  in  1  counting enable; 0 freezes prescaler and time.
- mode_12h  in  1  display select: 1 = 12-hour, 0 = 24-hour; affects outputs only.
- digit  in  6  one-hot field select: [5] sec0, [4] sec1, [3] min0, [2] min1, [1] hrs0, [0] hrs1.
- up  in  1  increment request for the selected field (level; rising edge acts).
- down  in  1  decrement request for the selected field (level; rising edge acts).
- sec0, sec1, min0, min1  out  4 each  BCD seconds/minutes digits.
- hrs0, hrs1  out  4 each  BCD hour digits, per mode_12h.
- pm  out  1  1 when hour ≥ 12 (valid in both modes).
- sec_tick  out  1  one-cycle pulse, first cycle a tick-advanced time is visible.
- day_tick  out  1  one-cycle pulse coincident with sec_tick on the 23:59:59 → 00:00:00 rollover.

## Operation
- State: prescaler pre[PW-1:0]; BCD sec0 (0-9), sec1 (0-5), min0 (0-9), min1 (0-5); binary hour hr[4:0] (0-23); up_q, down_q edge registers.
- Prescaler: when run=1 and set mode is inactive, pre counts 0..DIV-1. At pre==DIV-1 it wraps to 0 and an internal tick fires.
- On tick:
  - sec0 increments.
  - 9→0 carries into sec1; 5→0 carries into min0, then min1, then hr.
  - hr 23→0 asserts day_tick.
- Set mode = digit != 0.
  - While active, pre is forced to 0 and ticks are suppressed.
  - On exit, the first tick is DIV cycles later.
- Adjust event = exactly one digit bit set AND (up & ~up_q XOR down & ~down_q).
  - Both edges in the same cycle: no action.
  - Non-one-hot digit: no action.
  - A held button produces one adjust only.
- Adjust ranges (wrap, no carry into neighbouring fields):
  - sec0, min0: 0↔9.
  - sec1, min1: 0↔5.
  - hrs0: hr ±1 mod 24.
  - hrs1: hr ±10 mod 24 (e.g. 20+10 → 6; 3−10 → 17).
- Hour display, combinational from hr and mode_12h:
  - 24-hour mode: hrs1:hrs0 = BCD(hr).
  - 12-hour mode: BCD(hr==0 ? 12 : hr>12 ? hr−12 : hr).
  - pm = (hr ≥ 12).
- Illegal BCD values are unreachable; no code value > its field maximum ever appears.

## Timing
- All state registers update on the clk_6mhz rising edge. rst has priority over every other input.
- Reset values:
  - pre = 0; time 00:00:00 (hr=0); up_q = down_q = 0; sec_tick = day_tick = 0.
  - Display after reset: 00 in 24-hour mode; 12, pm=0 in 12-hour mode.
- Tick latency: the cycle where pre==DIV-1 and run=1 is followed by the edge that updates time. sec_tick/day_tick are high for exactly that next cycle.
- Tick period: exactly DIV cycles while run=1. run=0 holds pre, so no phase is lost.
- Adjust latency: the edge after the up/down rising edge is sampled updates the field. Adjust and tick cannot coincide, because set mode suppresses ticks.
- mode_12h change: reflected on hrs0/hrs1/pm in the same cycle (combinational); stored time is unaffected.
- rst asserted mid-count or mid-adjust: time returns to 00:00:00 next edge; no strobe is emitted.

## Test plan
- DIV=4, rst 1 cycle, run=1 → sec0 = 1 after 4 cycles, with sec_tick high 1 cycle. Period is exactly 4 cycles over 20 seconds.
- Preload 23:59:59 via adjusts, run=1 → next tick gives 00:00:00 with sec_tick=day_tick=1 for one cycle.
- 12-hour mode, hr stepped 0,1,11,12,13,23 via hrs0 up → displays 12/0, 01/0, 11/0, 12/1, 01/1, 11/1 (value/pm).
- digit=6'b000001 at hr=20, up pulse → hr 6. Second pulse with down → hr 20. Holding up 10 cycles → one increment only.
- digit=6'b100000, sec0=9, up → sec0=0 with sec1 unchanged. digit=6'b100100 with up → no change. up and down rising together → no change.
- run=1 with pre mid-count, assert digit for 3 cycles then release → first tick exactly DIV cycles after release. rst during count → 00:00:00 and no strobes.
